// File: rtl/ram_sdp_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module      : ram_sdp_rd_streamer
// Description : Burst read initiator for a simple-dual-port RAM. It turns a
//               (base address, word count) command into sequential RAM reads,
//               absorbs the fixed RAM read latency with a credit-controlled
//               output FIFO, and presents the words as a valid/ready stream
//               with an end-of-burst marker.
// Options     : RAM_SDP_RD_STREAMER_ABORT_EN adds an 'abort' input that
//               flushes an active burst without a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sdp_rd_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
`ifdef RAM_SDP_RD_STREAMER_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  out_last
);

    // FIFO holds every read that may be in flight plus two words of slack,
    // which is what lets the stream run without bubbles.
    localparam int c_depth = RD_LATENCY + 2;
    localparam int c_ptr_w = $clog2(c_depth);
    localparam int c_occ_w = $clog2(c_depth + 1);
    localparam int c_sum_w = c_occ_w + 1;

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $fatal(1, "ram_sdp_rd_streamer: RD_LATENCY must be 1 or 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    w_load;
    logic                    w_issue;
    logic                    w_pop;
    logic                    w_capture;
    logic                    w_abort;
    logic                    w_credit;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH:0]     r_issue_rem;
    logic [ADDR_WIDTH:0]     r_out_rem;
    logic [RD_LATENCY-1:0]   r_tags;
    logic [RD_LATENCY-1:0]   w_tags_nxt;
    logic [c_occ_w-1:0]      w_inflight;
    logic [c_occ_w-1:0]      r_occ;
    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [DATA_WIDTH-1:0]   r_fifo [c_depth];

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(c_depth - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

`ifdef RAM_SDP_RD_STREAMER_ABORT_EN
    assign w_abort = abort && (r_state == ST_RUN);
`else
    assign w_abort = 1'b0;
`endif

    assign busy        = (r_state == ST_RUN);
    assign ram_rd_en   = (r_state == ST_RUN);
    assign ram_rd_addr = r_addr;
    assign done        = r_done;
    assign out_valid   = (r_occ != '0);
    assign out_data    = r_fifo[r_rd_ptr];
    assign out_last    = out_valid && (r_out_rem == (ADDR_WIDTH+1)'(1));
    assign w_pop       = out_valid && out_ready;
    assign w_capture   = r_tags[RD_LATENCY-1];

    // Count real reads still travelling through the RAM pipeline.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + c_occ_w'(r_tags[i]);
        end
    end

    // Next state, command load, issue decision and done generation.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_credit    = (c_sum_w'(r_occ) + c_sum_w'(w_inflight)) < c_sum_w'(c_depth);
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                w_issue = (r_issue_rem != '0) && w_credit;
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_pop && out_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Tag shift register mirrors the RAM read pipeline; a 1 marks a real read.
    generate
        if (RD_LATENCY == 1) begin : g_tag_single
            assign w_tags_nxt = w_issue;
        end else begin : g_tag_chain
            assign w_tags_nxt = {r_tags[RD_LATENCY-2:0], w_issue};
        end
    endgenerate

    // Tag pipeline register, cleared on abort so stale reads are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tags <= '0;
        end else if (w_abort) begin
            r_tags <= '0;
        end else begin
            r_tags <= w_tags_nxt;
        end
    end

    // Address counter and the issue / output remaining counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_issue_rem <= '0;
            r_out_rem   <= '0;
        end else if (w_load) begin
            r_addr      <= base_addr;
            r_issue_rem <= count;
            r_out_rem   <= count;
        end else begin
            if (w_issue) begin
                r_addr      <= r_addr + ADDR_WIDTH'(1);
                r_issue_rem <= r_issue_rem - (ADDR_WIDTH+1)'(1);
            end
            if (w_pop) begin
                r_out_rem   <= r_out_rem - (ADDR_WIDTH+1)'(1);
            end
        end
    end

    // FIFO pointers and occupancy; abort empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (w_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_capture) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_capture, w_pop})
                2'b10:   r_occ <= r_occ + c_occ_w'(1);
                2'b01:   r_occ <= r_occ - c_occ_w'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // FIFO storage; cleared on reset so out_data starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_depth; i++) begin
                r_fifo[i] <= '0;
            end
        end else if (w_capture && !w_abort) begin
            r_fifo[r_wr_ptr] <= ram_rd_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_sdp_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_sdp_rd_streamer
// Description : Self-checking bench for ram_sdp_rd_streamer. Two instances
//               (RD_LATENCY 2 and 1) each read a behavioural RAM model;
//               expected words are queued when a burst is commanded and
//               compared as the stream hands them over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sdp_rd_streamer;

    localparam int AW = 10;
    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          out_ready;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          start_s     [2];
    logic          abort_s     [2];
    logic          busy        [2];
    logic          done        [2];
    logic          ram_rd_en   [2];
    logic          out_valid   [2];
    logic          out_last    [2];
    logic [AW-1:0] ram_rd_addr [2];
    logic [DW-1:0] ram_rd_data [2];
    logic [DW-1:0] out_data    [2];

    logic [DW-1:0] mem [1024];
    logic [DW-1:0] ram0_s1, ram0_s2, ram1_s1;

    exp_t q0[$];
    exp_t q1[$];

    int   checks = 0;
    int   errors = 0;
    int   hs_cnt    [2] = '{0, 0};
    int   done_cnt  [2] = '{0, 0};
    int   rd_en_cnt [2] = '{0, 0};
    logic exp_done   [2] = '{1'b0, 1'b0};
    logic prev_stall [2] = '{1'b0, 1'b0};
    logic prev_last  [2] = '{1'b0, 1'b0};
    logic [DW-1:0] prev_data [2] = '{'0, '0};

    always #5 clk = ~clk;

    ram_sdp_rd_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .base_addr(base_addr),
        .count(count), .busy(busy[0]), .done(done[0]), .ram_rd_en(ram_rd_en[0]),
        .ram_rd_addr(ram_rd_addr[0]), .ram_rd_data(ram_rd_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
`ifdef RAM_SDP_RD_STREAMER_ABORT_EN
        .abort(abort_s[0]),
`endif
        .out_last(out_last[0])
    );

    ram_sdp_rd_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .base_addr(base_addr),
        .count(count), .busy(busy[1]), .done(done[1]), .ram_rd_en(ram_rd_en[1]),
        .ram_rd_addr(ram_rd_addr[1]), .ram_rd_data(ram_rd_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
`ifdef RAM_SDP_RD_STREAMER_ABORT_EN
        .abort(abort_s[1]),
`endif
        .out_last(out_last[1])
    );

    // RAM models: read stages advance only while rd_en is high.
    always @(posedge clk) begin
        if (ram_rd_en[0]) begin
            ram0_s1 <= mem[ram_rd_addr[0]];
            ram0_s2 <= ram0_s1;
        end
        if (ram_rd_en[1]) begin
            ram1_s1 <= mem[ram_rd_addr[1]];
        end
    end
    assign ram_rd_data[0] = ram0_s2;
    assign ram_rd_data[1] = ram1_s1;

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    function automatic int qsize(input int idx);
        return (idx == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void push_exp(input int idx, input int base, input int cnt);
        exp_t e;
        for (int k = 0; k < cnt; k++) begin
            e.data = mem[AW'((base + k) % 1024)];
            e.last = (k == cnt - 1);
            if (idx == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
    endfunction

    // Stream monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin : p_mon
        logic nd;
        logic abort_now;
        exp_t e;
        int   sz;
        if (rst_n) begin
            chk("occupancy_a", 0, 32'(32'(dut_a.r_occ) <= 32'd4), 32'd1);
            chk("occupancy_b", 1, 32'(32'(dut_b.r_occ) <= 32'd3), 32'd1);
        end
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                exp_done[i]   = 1'b0;
                prev_stall[i] = 1'b0;
            end else begin
                chk("done", i, 32'(done[i]), 32'(exp_done[i]));
                if (done[i]) done_cnt[i]++;
                if (ram_rd_en[i]) rd_en_cnt[i]++;
                if (!out_valid[i]) chk("last_without_valid", i, 32'(out_last[i]), 32'd0);
                if (prev_stall[i]) begin
                    chk("stall_valid", i, 32'(out_valid[i]), 32'd1);
                    chk("stall_data", i, 32'(out_data[i]), 32'(prev_data[i]));
                    chk("stall_last", i, 32'(out_last[i]), 32'(prev_last[i]));
                end
                nd        = 1'b0;
                abort_now = abort_s[i] && busy[i];
                if (out_valid[i] && out_ready && !abort_now) begin
                    sz = qsize(i);
                    chk("word_expected", i, 32'(sz != 0), 32'd1);
                    if (sz != 0) begin
                        if (i == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk("data", i, 32'(out_data[i]), 32'(e.data));
                        chk("last", i, 32'(out_last[i]), 32'(e.last));
                    end
                    hs_cnt[i]++;
                    nd = out_last[i];
                end
                if (start_s[i] && !busy[i] && count == '0) nd = 1'b1;
                exp_done[i]   = nd;
                prev_stall[i] = out_valid[i] && !out_ready && !abort_now;
                prev_data[i]  = out_data[i];
                prev_last[i]  = out_last[i];
            end
        end
    end

    task automatic check_reset(input int idx);
        chk("rst_busy",  idx, 32'(busy[idx]),        32'd0);
        chk("rst_done",  idx, 32'(done[idx]),        32'd0);
        chk("rst_rd_en", idx, 32'(ram_rd_en[idx]),   32'd0);
        chk("rst_addr",  idx, 32'(ram_rd_addr[idx]), 32'd0);
        chk("rst_valid", idx, 32'(out_valid[idx]),   32'd0);
        chk("rst_last",  idx, 32'(out_last[idx]),    32'd0);
        chk("rst_data",  idx, 32'(out_data[idx]),    32'd0);
    endtask

    // Drives start one cycle and returns one cycle later (posedge + 1).
    task automatic pulse_start(input int idx, input int base, input int cnt);
        base_addr    = AW'(base);
        count        = (AW+1)'(cnt);
        start_s[idx] = 1'b1;
        @(posedge clk); #1;
        start_s[idx] = 1'b0;
    endtask

    // Full burst with out_ready high: latency, gap-free span, word and done counts.
    task automatic burst(input int idx, input int base, input int cnt, input int lat);
        int n, m, hs0, dn0;
        hs0 = hs_cnt[idx];
        dn0 = done_cnt[idx];
        push_exp(idx, base, cnt);
        out_ready = 1'b1;
        pulse_start(idx, base, cnt);
        n = 1;
        @(negedge clk);
        while (!out_valid[idx] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("first_valid_latency", idx, 32'(n), 32'(lat));
        m = 0;
        while (busy[idx] && m < 200) begin
            @(negedge clk);
            m++;
        end
        chk("burst_span", idx, 32'(m), 32'(cnt));
        @(posedge clk); #1;
        chk("burst_words", idx, 32'(hs_cnt[idx] - hs0), 32'(cnt));
        chk("done_pulses", idx, 32'(done_cnt[idx] - dn0), 32'd1);
        chk("queue_drained", idx, 32'(qsize(idx)), 32'd0);
    endtask

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        int hs0, dn0, rd0, k;
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i + 100);
        rst_n      = 1'b0;
        out_ready  = 1'b1;
        base_addr  = '0;
        count      = '0;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        abort_s[0] = 1'b0;
        abort_s[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic bursts and address wrap on both latencies.
        burst(0, 5, 4, 4);
        burst(1, 5, 4, 3);
        burst(0, 1022, 4, 4);
        burst(1, 1022, 4, 3);

        // Backpressure with random ready and two 10-cycle stalls.
        hs0 = hs_cnt[0];
        dn0 = done_cnt[0];
        push_exp(0, 300, 16);
        pulse_start(0, 300, 16);
        for (int c = 0; c < 400 && (busy[0] || q0.size() != 0); c++) begin
            if ((c >= 5 && c < 15) || (c >= 30 && c < 40)) out_ready = 1'b0;
            else                                            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("bp_still_busy", 0, 32'(busy[0]), 32'd0);
        @(posedge clk); #1;
        chk("bp_words", 0, 32'(hs_cnt[0] - hs0), 32'd16);
        chk("bp_done_pulses", 0, 32'(done_cnt[0] - dn0), 32'd1);
        chk("bp_queue_drained", 0, 32'(q0.size()), 32'd0);

        // Zero-count command: done next cycle, no reads.
        rd0 = rd_en_cnt[0];
        dn0 = done_cnt[0];
        pulse_start(0, 7, 0);
        @(negedge clk);
        chk("zero_done", 0, 32'(done[0]), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("zero_rd_en", 0, 32'(rd_en_cnt[0] - rd0), 32'd0);
        chk("zero_done_pulses", 0, 32'(done_cnt[0] - dn0), 32'd1);
        chk("zero_busy", 0, 32'(busy[0]), 32'd0);

        // Start pulsed mid-burst is ignored.
        hs0 = hs_cnt[0];
        dn0 = done_cnt[0];
        push_exp(0, 50, 8);
        pulse_start(0, 50, 8);
        repeat (3) @(posedge clk);
        #1;
        pulse_start(0, 0, 3);
        k = 0;
        while (busy[0] && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        chk("ign_words", 0, 32'(hs_cnt[0] - hs0), 32'd8);
        chk("ign_done_pulses", 0, 32'(done_cnt[0] - dn0), 32'd1);
        chk("ign_queue_drained", 0, 32'(q0.size()), 32'd0);

        // Asynchronous reset after 3 of 8 words.
        hs0 = hs_cnt[0];
        push_exp(0, 400, 8);
        pulse_start(0, 400, 8);
        k = 0;
        while ((hs_cnt[0] - hs0) < 3 && k < 100) begin
            @(posedge clk); #2;
            k++;
        end
        chk("rst_wait_words", 0, 32'(hs_cnt[0] - hs0), 32'd3);
        rst_n = 1'b0;
        #1;
        check_reset(0);
        check_reset(1);
        q0.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        burst(0, 10, 2, 4);

`ifdef RAM_SDP_RD_STREAMER_ABORT_EN
        // Abort in the cycle after the 2nd of 8 handshakes.
        hs0 = hs_cnt[0];
        dn0 = done_cnt[0];
        push_exp(0, 600, 8);
        pulse_start(0, 600, 8);
        k = 0;
        while ((hs_cnt[0] - hs0) < 2 && k < 100) begin
            @(posedge clk); #2;
            k++;
        end
        abort_s[0] = 1'b1;
        out_ready  = 1'b0;
        @(posedge clk); #1;
        abort_s[0] = 1'b0;
        chk("abort_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("abort_rd_en", 0, 32'(ram_rd_en[0]), 32'd0);
        chk("abort_busy", 0, 32'(busy[0]), 32'd0);
        q0.delete();
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_words", 0, 32'(hs_cnt[0] - hs0), 32'd2);
        chk("abort_no_done", 0, 32'(done_cnt[0] - dn0), 32'd0);
        burst(0, 700, 3, 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
